// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, types and requester indices for the writeback arbiter and its scoreboard.
package regfile_wb_arbiter_pkg;

    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned WB_REQ_NUM = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [$clog2(WB_REQ_NUM)-1:0] {
        WbReq0 = 1'b0,
        WbReq1 = 1'b1
    } wb_req_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, issue claim, regfile write and decode read signals of the arbiter.
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic            req0_valid_i;
    reg_addr_t       req0_addr_i;
    reg_data_t       req0_data_i;
    logic            req0_ready_o;
    logic            req1_valid_i;
    reg_addr_t       req1_addr_i;
    reg_data_t       req1_data_i;
    logic            req1_ready_o;
    logic            claim_i;
    reg_addr_t       claim_addr_i;
    logic            we_o;
    reg_addr_t       waddr_o;
    reg_data_t       wdata_o;
    logic            re1_i;
    reg_addr_t       raddr1_i;
    logic            re2_i;
    reg_addr_t       raddr2_i;
    logic            stall_o;
    logic [NREG-1:0] busy_o;

    modport master (
        output req0_valid_i, req0_addr_i, req0_data_i,
        output req1_valid_i, req1_addr_i, req1_data_i,
        output claim_i, claim_addr_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  req0_ready_o, req1_ready_o,
        input  we_o, waddr_o, wdata_o,
        input  stall_o, busy_o
    );

    modport slave (
        input  req0_valid_i, req0_addr_i, req0_data_i,
        input  req1_valid_i, req1_addr_i, req1_data_i,
        input  claim_i, claim_addr_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output req0_ready_o, req1_ready_o,
        output we_o, waddr_o, wdata_o,
        output stall_o, busy_o
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on claim, cleared on commit,
// and the decode RAW stall derived from it.
module regfile_wb_arbiter_scoreboard
    import regfile_wb_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            claim,
    input  reg_addr_t       claim_addr,
    input  logic            clr,
    input  reg_addr_t       clr_addr,
    input  logic            re1,
    input  reg_addr_t       raddr1,
    input  logic            re2,
    input  reg_addr_t       raddr2,
    output logic [NREG-1:0] busy,
    output logic            stall
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            hit1, hit2;

    // Claim is applied after clear so a back-to-back writer keeps the register reserved.
    always_comb begin
        busy_d = busy_q;
        if (clr) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (claim && (claim_addr != '0)) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A read of the register being written this cycle is served by the regfile bypass.
    always_comb begin
        hit1  = re1 && busy_q[raddr1] && (raddr1 != '0) && !(clr && (clr_addr == raddr1));
        hit2  = re2 && busy_q[raddr2] && (raddr2 != '0) && !(clr && (clr_addr == raddr2));
        stall = !rst && (hit1 || hit2);
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile write port between the EX and MEM writeback
// paths, with a registered write port and the pending-write scoreboard beside it.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    wb_req_e   last_grant;
    logic      grant0, grant1;
    reg_addr_t gnt_addr;
    reg_data_t gnt_data;
    logic      we_q;
    reg_addr_t waddr_q;
    reg_data_t wdata_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (bus.req0_valid_i && bus.req1_valid_i) begin
                grant0 = (last_grant == WbReq1);
                grant1 = (last_grant == WbReq0);
            end else begin
                grant0 = bus.req0_valid_i;
                grant1 = bus.req1_valid_i;
            end
        end
        gnt_addr = grant1 ? bus.req1_addr_i : bus.req0_addr_i;
        gnt_data = grant1 ? bus.req1_data_i : bus.req0_data_i;
    end

    // Writes to x0 are consumed but never reach the regfile.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            last_grant <= WbReq1;
        end else if (grant0 || grant1) begin
            we_q       <= (gnt_addr != '0);
            waddr_q    <= gnt_addr;
            wdata_q    <= gnt_data;
            last_grant <= grant1 ? WbReq1 : WbReq0;
        end else begin
            we_q       <= 1'b0;
        end
    end

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign bus.we_o         = we_q;
    assign bus.waddr_o      = waddr_q;
    assign bus.wdata_o      = wdata_q;

    regfile_wb_arbiter_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .claim      (bus.claim_i),
        .claim_addr (bus.claim_addr_i),
        .clr        (we_q),
        .clr_addr   (waddr_q),
        .re1        (bus.re1_i),
        .raddr1     (bus.raddr1_i),
        .re2        (bus.re2_i),
        .raddr2     (bus.raddr2_i),
        .busy       (bus.busy_o),
        .stall      (bus.stall_o)
    );

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: req0 (EX/ALU result) and req1 (MEM/load result). Grants are round-robin, and the granted write is registered onto the regfile write port. The block also holds a 32-entry pending-write scoreboard, claimed at issue and cleared at commit. From it, the block drives a stall to the decode stage whenever a decode-stage read hits a register with a write still outstanding. It sits between the pipeline writeback paths and regfile, beside the ID stage.

Parameters:
ADDR_W, 5, register address width (`RegNumLog2)
DATA_W, 32, register data width (`RegBus)
NREG, 32, number of architectural registers (`RegNum)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high (`RstEnable)
req0_valid_i  in  1  EX writeback request
req0_addr_i  in  ADDR_W  destination register
req0_data_i  in  DATA_W  result data
req0_ready_o  out  1  req0 granted this cycle
req1_valid_i  in  1  MEM writeback request
req1_addr_i  in  ADDR_W  destination register
req1_data_i  in  DATA_W  load data
req1_ready_o  out  1  req1 granted this cycle
claim_i  in  1  issue-stage reservation of a destination
claim_addr_i  in  ADDR_W  register being reserved
we_o  out  1  regfile write enable (`WriteEnable)
waddr_o  out  ADDR_W  regfile write address
wdata_o  out  DATA_W  regfile write data
re1_i  in  1  decode read enable, port 1
raddr1_i  in  ADDR_W  decode read address, port 1
re2_i  in  1  decode read enable, port 2
raddr2_i  in  ADDR_W  decode read address, port 2
stall_o  out  1  decode must stall (RAW on pending write)
busy_o  out  NREG  scoreboard vector, debug and observation only

Behaviour:
- Reset, sampled at posedge clk while rst=1: we_o=0, waddr_o=0, wdata_o=0, busy=0, last_grant=1 (so req0 wins the first tie).
- While rst=1, ready_o=0 and stall_o=0.
- Arbitration (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester other than last_grant.
  - Neither valid: no grant.
  - At most one ready_o is high per cycle.
  - A request that is valid and not granted must hold its addr/data until granted; the bench checks this.
- Grant cycle N:
  - At the end of N: we_o <= (granted addr != 0), waddr_o <= addr, wdata_o <= data, last_grant <= granted index.
  - With no grant: we_o <= 0, and waddr_o/wdata_o hold their values.
  - Latency from handshake to we_o is 1 cycle. The regfile commits at the end of N+1.
  - A request to x0 is accepted and consumed but produces no write.
- Scoreboard:
  - busy[0] is always 0.
  - claim_i=1 with claim_addr_i != 0: busy[addr] <= 1 at the clock edge.
  - we_o=1: busy[waddr_o] <= 0 at the same edge the regfile commits.
  - Simultaneous claim and clear of the same address: claim wins, busy stays 1 (back-to-back writers).
  - Claiming an already-busy register is legal; busy stays 1. There is a single bit per register, no counting.
- Stall (combinational):
  - hitK = reK_i & busy[raddrK_i] & (raddrK_i != 0) & ~(we_o & waddr_o == raddrK_i).
  - The last term exists because the regfile bypasses same-cycle write data to the read ports.
  - stall_o = hit1 | hit2.
- Reset mid-operation: all pending claims and any registered write are dropped. Upstream is flushed by the same reset.
- Starvation: under continuous contention the grants strictly alternate, so neither requester waits more than 1 cycle.

Decomposition:
- The shared defines header gains `WbReqNum (2) and `WbReq0/`WbReq1 index constants.
- The existing `RegAddrBus/`RegBus/`WriteEnable/`RstEnable macros are reused.
- One natural sub-module: wb_scoreboard, holding the busy vector, the claim/clear update and the stall compare.
- The arbiter and output register stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with both requests valid -> ready_o=00, we_o=0, busy_o=0, stall_o=0. Deassert -> first tie grants req0.
- Contention: req0 (x5, 0x11) and req1 (x6, 0x22) both held valid -> grants alternate req0, req1. we_o pulses: x5=0x11 at N+1, then x6=0x22 at N+2.
- Scoreboard: claim x7 in cycle 0; decode reads raddr1=x7 with re1=1 -> stall_o=1. req1 writes x7=0xDEAD -> stall_o drops in the cycle we_o=1 (bypass term). busy[7]=0 the following cycle.
- Claim/clear collision: we_o committing x9 while claim_i targets x9 in the same cycle -> busy[9] remains 1 and stall persists for a subsequent read of x9.
- x0 handling: claim x0 and request a write to x0 with data 0xFFFFFFFF -> busy[0]=0, ready=1, we_o stays 0. A read of x0 never stalls.
- Mid-flight reset: with busy={x3,x4} and a write to x3 registered, assert rst for 1 cycle -> busy_o=0, we_o=0 next cycle, no stall.
